// File: rtl/system.sv
// rtl/system.sv - externally sequenced single-bus 32-bit datapath with 512x32 RAM
// Optional loader override write port enabled by SYSTEM_MEM_OVERRIDE_EN.
module system #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] inport_data,
  input  logic                  inport_data_ready,
  output logic [DATA_WIDTH-1:0] outport_data,
  input  logic                  outport_in,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  CONin,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  output logic                  con_ff_bit,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in
);

  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  logic [DATA_WIDTH-1:0] r_q [16];
  logic [DATA_WIDTH-1:0] r_d [16];
  logic [DATA_WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mar_q, mar_d, mdr_q, mdr_d, y_q, y_d;
  logic [DATA_WIDTH-1:0] zhi_q, zhi_d, zlo_q, zlo_d;
  logic [DATA_WIDTH-1:0] inport_q, inport_d, outport_q, outport_d;
  logic                  con_q, con_d;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   mar_addr;
  logic [DATA_WIDTH-1:0]   mem_rdata, bus, c_sext, alu_hi, alu_lo;
  logic [3:0]              reg_idx;
  logic [4:0]              shamt;
  logic [2*DATA_WIDTH-1:0] rot;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                    unused_bits;

  assign mar_addr  = mar_q[ADDR_WIDTH-1:0];
  assign mem_rdata = mem[mar_addr];
  assign c_sext    = {{(DATA_WIDTH-19){ir_q[18]}}, ir_q[18:0]};

  assign outport_data        = outport_q;
  assign con_ff_bit          = con_q;
  assign Mem_to_datapath_out = mem_rdata;
  assign MAR_address_out     = mar_addr;

`ifdef SYSTEM_MEM_OVERRIDE_EN
  assign Mem_data_to_chip_out = mem_overide ? overide_data_in : mdr_q;
  assign unused_bits = ^{ir_q[31:27], mar_q[DATA_WIDTH-1:ADDR_WIDTH]};
`else
  assign Mem_data_to_chip_out = mdr_q;
  assign unused_bits = ^{ir_q[31:27], mar_q[DATA_WIDTH-1:ADDR_WIDTH],
                         mem_overide, overide_address, overide_data_in};
`endif

  // Simultaneous Gra/Grb/Grc assertions merge their fields bitwise
  always_comb begin
    reg_idx = 4'd0;
    if (Gra) reg_idx = reg_idx | ir_q[26:23];
    if (Grb) reg_idx = reg_idx | ir_q[22:19];
    if (Grc) reg_idx = reg_idx | ir_q[18:15];
  end

  always_comb begin
    bus = '0;
    if (Rout || BAout)   bus = (BAout && reg_idx == 4'd0) ? '0 : r_q[reg_idx];
    else if (HIout)      bus = hi_q;
    else if (LOout)      bus = lo_q;
    else if (Zhi_out)    bus = zhi_q;
    else if (Zlo_out)    bus = zlo_q;
    else if (PCout)      bus = pc_q;
    else if (MDRout)     bus = mdr_q;
    else if (Inport_out) bus = inport_q;
    else if (Cout)       bus = c_sext;
  end

  always_comb begin
    shamt  = bus[4:0];
    rot    = '0;
    prod   = $signed({{DATA_WIDTH{y_q[DATA_WIDTH-1]}}, y_q}) *
             $signed({{DATA_WIDTH{bus[DATA_WIDTH-1]}}, bus});
    alu_hi = '0;
    alu_lo = bus;
    if (IncPC) begin
      alu_lo = bus + ONE;
    end else begin
      case (opcode)
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: alu_lo = y_q + bus;
        5'b00100:           alu_lo = y_q - bus;
        5'b00101, 5'b01101: alu_lo = y_q & bus;
        5'b00110, 5'b01110: alu_lo = y_q | bus;
        5'b00111:           alu_lo = y_q >> shamt;
        5'b01000:           alu_lo = $signed(y_q) >>> shamt;
        5'b01001:           alu_lo = y_q << shamt;
        5'b01010: begin
          rot    = {y_q, y_q} >> shamt;
          alu_lo = rot[DATA_WIDTH-1:0];
        end
        5'b01011: begin
          rot    = {y_q, y_q} << shamt;
          alu_lo = rot[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        5'b01111:           {alu_hi, alu_lo} = prod;
        5'b10000: begin
          if (bus != '0) begin
            alu_lo = $signed(y_q) / $signed(bus);
            alu_hi = $signed(y_q) % $signed(bus);
          end else begin
            alu_lo = '0;
          end
        end
        5'b10001:           alu_lo = -bus;
        5'b10010:           alu_lo = ~bus;
        default:            alu_lo = bus;
      endcase
    end
  end

  always_comb begin
    r_d       = r_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    y_d       = y_q;
    zhi_d     = zhi_q;
    zlo_d     = zlo_q;
    inport_d  = inport_q;
    outport_d = outport_q;
    con_d     = con_q;
    if (Rin)   r_d[reg_idx] = bus;
    if (HIin)  hi_d  = bus;
    if (LOin)  lo_d  = bus;
    if (PCin)  pc_d  = bus;
    if (IRin)  ir_d  = bus;
    if (MARin) mar_d = bus;
    if (MDRin) mdr_d = Mem_Read ? mem_rdata : bus;
    if (Yin)   y_d   = bus;
    if (Zin) begin
      zhi_d = alu_hi;
      zlo_d = alu_lo;
    end
    if (inport_data_ready) inport_d  = inport_data;
    if (outport_in)        outport_d = bus;
    if (CONin) begin
      case (ir_q[20:19])
        2'b00:   con_d = (bus == '0);
        2'b01:   con_d = (bus != '0);
        2'b10:   con_d = ~bus[DATA_WIDTH-1];
        default: con_d = bus[DATA_WIDTH-1];
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
      con_q     <= 1'b0;
    end else begin
      r_q       <= r_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      zhi_q     <= zhi_d;
      zlo_q     <= zlo_d;
      inport_q  <= inport_d;
      outport_q <= outport_d;
      con_q     <= con_d;
    end
  end

  // RAM contents survive clear
  always_ff @(posedge Clock) begin
`ifdef SYSTEM_MEM_OVERRIDE_EN
    if (mem_overide && Mem_enable512x32) mem[overide_address] <= overide_data_in;
    else if (Mem_enable512x32 && Mem_Write) mem[mar_addr] <= mdr_q;
`else
    if (Mem_enable512x32 && Mem_Write) mem[mar_addr] <= mdr_q;
`endif
  end

endmodule

// File: tb/tb_system.sv
// tb/tb_system.sv - scoreboard bench for system with randomized ALU, CON and RAM stimulus
module tb_system;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] inport_data;
  logic        inport_data_ready;
  logic [31:0] outport_data;
  logic        outport_in;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin;
  logic [4:0]  opcode;
  logic        IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
  logic        con_ff_bit;
  logic        Mem_Read, Mem_Write, Mem_enable512x32;
  logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out;
  logic [8:0]  MAR_address_out;
  logic        mem_overide;
  logic [8:0]  overide_address;
  logic [31:0] overide_data_in;

  always #5 Clock = ~Clock;

  system dut (
    .Clock(Clock), .clear(clear),
    .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .outport_data(outport_data), .outport_in(outport_in),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
    .opcode(opcode), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .con_ff_bit(con_ff_bit),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
    .Mem_to_datapath_out(Mem_to_datapath_out), .Mem_data_to_chip_out(Mem_data_to_chip_out),
    .MAR_address_out(MAR_address_out), .mem_overide(mem_overide),
    .overide_address(overide_address), .overide_data_in(overide_data_in)
  );

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  logic        obs_req = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_mem [int];

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return outport_data;
      1:       return {31'b0, con_ff_bit};
      2:       return Mem_to_datapath_out;
      3:       return {23'b0, MAR_address_out};
      default: return Mem_data_to_chip_out;
    endcase
  endfunction

  always @(negedge Clock) begin
    if (obs_req) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: observation with no expected value");
      end else begin
        mon_e   = sb_q.pop_front();
        mon_act = observe(mon_e.sel);
        if (mon_act !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  function automatic logic [63:0] ref_alu(logic [4:0] op, logic inc, logic [31:0] a, logic [31:0] b);
    logic [31:0] lo, hi;
    int s;
    longint p;
    s  = int'(b & 32'd31);
    hi = 32'h0;
    if (inc) return {32'h0, b + 32'd1};
    case (op)
      0, 1, 2, 3, 12: lo = a + b;
      4:       lo = a - b;
      5, 13:   lo = a & b;
      6, 14:   lo = a | b;
      7:       lo = a >> s;
      8:       lo = int'(a) >>> s;
      9:       lo = a << s;
      10:      lo = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      11:      lo = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
      15: begin
        p = longint'(int'(a)) * longint'(int'(b));
        return p;
      end
      16: begin
        if (b == 32'h0) return 64'h0;
        lo = int'(a) / int'(b);
        hi = int'(a) % int'(b);
      end
      17:      lo = 32'h0 - b;
      18:      lo = ~b;
      default: lo = b;
    endcase
    return {hi, lo};
  endfunction

  function automatic logic ref_con(logic [1:0] cc, logic [31:0] v);
    case (cc)
      2'd0:    return v == 32'h0;
      2'd1:    return v != 32'h0;
      2'd2:    return int'(v) >= 0;
      default: return int'(v) < 0;
    endcase
  endfunction

  function automatic logic [31:0] fa(int k);
    return 32'(k & 15) << 23;
  endfunction

  task automatic clr_ctrl();
    {clear, inport_data_ready, outport_in, HIout, LOout, Zhi_out, Zlo_out, PCout} = '0;
    {MDRout, Inport_out, Cout, MARin, Zin, PCin, MDRin, IRin, Yin} = '0;
    {HIin, LOin, CONin, IncPC, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {Mem_Read, Mem_Write, Mem_enable512x32, mem_overide} = '0;
    opcode = 5'd0;
    overide_address = 9'd0;
    overide_data_in = 32'h0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    clr_ctrl();
  endtask

  task automatic expect_v(int sel, logic [31:0] v, string name);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = name;
    sb_q.push_back(e);
    obs_req = 1'b1;
    @(posedge Clock);
    #1;
    obs_req = 1'b0;
  endtask

  task automatic put_in(logic [31:0] v);
    inport_data = v; inport_data_ready = 1'b1; tick();
  endtask

  task automatic set_ir(logic [31:0] v);
    put_in(v); Inport_out = 1'b1; IRin = 1'b1; tick();
  endtask

  task automatic write_reg(int k, logic [31:0] v);
    set_ir(fa(k));
    put_in(v); Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
  endtask

  task automatic show_reg(int k, logic [31:0] v, string name);
    set_ir(fa(k));
    Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, v, name);
  endtask

  task automatic set_mar(logic [31:0] a);
    put_in(a); Inport_out = 1'b1; MARin = 1'b1; tick();
  endtask

  task automatic mem_write(logic [31:0] a, logic [31:0] v);
    set_mar(a);
    put_in(v); Inport_out = 1'b1; MDRin = 1'b1; tick();
    Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; tick();
    m_mem[int'(a & 32'h1FF)] = v;
  endtask

  task automatic fetch();
    PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1; tick();
    Zlo_out = 1'b1; PCin = 1'b1; MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; tick();
    MDRout = 1'b1; IRin = 1'b1; tick();
  endtask

  task automatic alu_seq(logic [4:0] op, logic inc, logic [31:0] a, logic [31:0] b,
                         logic [63:0] exp, string name);
    write_reg(2, a);
    write_reg(3, b);
    set_ir(fa(2)); Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; tick();
    set_ir(fa(3)); Gra = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; IncPC = inc; tick();
    Zlo_out = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, exp[31:0], $sformatf("%s lo op=%0d inc=%0d a=%h b=%h", name, op, inc, a, b));
    Zhi_out = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, exp[63:32], $sformatf("%s hi op=%0d inc=%0d a=%h b=%h", name, op, inc, a, b));
  endtask

  task automatic con_seq(logic [1:0] cc, logic [31:0] v, logic exp, string name);
    write_reg(4, v);
    set_ir(fa(4) | (32'(cc) << 19));
    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; tick();
    expect_v(1, {31'b0, exp}, $sformatf("%s cc=%0d v=%h", name, cc, v));
  endtask

  initial begin
    logic [4:0]  op;
    logic        inc;
    logic [31:0] a, b, v, addr;
    logic [1:0]  cc;
    int          addrs[$];

    inport_data = 32'h0;
    clr_ctrl();
    clear = 1'b1; tick();
    expect_v(0, 32'h0, "reset_outport");
    expect_v(1, 32'h0, "reset_con");
    expect_v(3, 32'h0, "reset_mar");
    expect_v(4, 32'h0, "reset_mdr");

    mem_write(32'h0, 32'h0B000003);
    mem_write(32'h1, 32'hA3000000);
    fetch();
    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; tick();
    Cout = 1'b1; Zin = 1'b1; opcode = 5'b00011; tick();
    Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; tick();
    show_reg(6, 32'd3, "ldi_r6");
    PCout = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, 32'd1, "pc_after_fetch");
    fetch();
    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; tick();
    PCout = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, 32'd3, "jr_r6_pc");

    write_reg(0, 32'h55);
    set_ir(fa(0));
    Gra = 1'b1; BAout = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, 32'h0, "baout_r0_zero");
    Gra = 1'b1; Rout = 1'b1; PCout = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, 32'h55, "rout_priority_over_pc");
    outport_in = 1'b1; tick();
    expect_v(0, 32'h0, "idle_bus_zero");

    alu_seq(5'b00011, 1'b0, 32'd7, 32'd5, 64'd12, "add");
    alu_seq(5'b00100, 1'b0, 32'd7, 32'd5, 64'd2, "sub");
    alu_seq(5'b01111, 1'b0, 32'hFFFFFFFD, 32'd4, 64'hFFFFFFFF_FFFFFFF4, "mul");
    alu_seq(5'b10000, 1'b0, 32'd9, 32'd0, 64'd0, "div_by_zero");

    for (int i = 0; i < 40; i++) begin
      op  = 5'($urandom_range(0, 31));
      inc = ($urandom_range(0, 7) == 0);
      a   = $urandom;
      b   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40)) - 32'd8;
      if (op == 5'd16 && $urandom_range(0, 3) == 0) b = 32'h0;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) a = 32'd1;
      alu_seq(op, inc, a, b, ref_alu(op, inc, a, b), "alu_rand");
    end

    con_seq(2'd0, 32'h0, 1'b1, "con_zero");
    con_seq(2'd0, 32'h1, 1'b0, "con_zero_on_one");
    for (int i = 0; i < 12; i++) begin
      cc = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      con_seq(cc, v, ref_con(cc, v), "con_rand");
    end

    mem_write(32'd5, 32'hDEADBEEF);
    expect_v(2, 32'hDEADBEEF, "ram5_readback");
    expect_v(3, 32'd5, "mar_addr5");
    set_mar(32'h205);
    expect_v(3, 32'd5, "mar_wrap");
    expect_v(2, 32'hDEADBEEF, "ram_wrap_read");
    MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; tick();
    expect_v(4, 32'hDEADBEEF, "mdr_from_ram");

    for (int i = 0; i < 8; i++) begin
      addr = $urandom;
      if ((addr & 32'h1FF) < 32'd16) addr = addr | 32'h10;
      mem_write(addr, $urandom);
      addrs.push_back(int'(addr & 32'h1FF));
    end
    foreach (addrs[i]) begin
      set_mar(32'(addrs[i]));
      expect_v(2, m_mem[addrs[i]], $sformatf("ram_rand addr=%0d", addrs[i]));
    end

    write_reg(2, 32'h1234);
    con_seq(2'd0, 32'h0, 1'b1, "con_before_clear");
    show_reg(2, 32'h1234, "r2_before_clear");
    put_in(32'h77); Inport_out = 1'b1; Yin = 1'b1; MARin = 1'b1; clear = 1'b1; tick();
    expect_v(0, 32'h0, "clear_outport");
    expect_v(1, 32'h0, "clear_con");
    expect_v(3, 32'h0, "clear_mar");
    expect_v(4, 32'h0, "clear_mdr");
    Zlo_out = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, 32'h0, "clear_zlo");
    PCout = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, 32'h0, "clear_pc");
    show_reg(2, 32'h0, "clear_r2");
    Cout = 1'b1; Zin = 1'b1; opcode = 5'b00000; tick();
    Zlo_out = 1'b1; outport_in = 1'b1; tick();
    expect_v(0, 32'h0, "clear_y_blocks_load");
    set_mar(32'd5);
    expect_v(2, 32'hDEADBEEF, "ram_kept_after_clear");

    for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge Clock);
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
